// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_stall_ctrl_pkg;

   localparam int unsigned CNT_W_DEF = 16;
   localparam int unsigned ST_W      = 2;
   localparam int unsigned OPC_W     = 5;

   // Controller state; encoding 2'd3 is unreachable and recovers to RUN.
   typedef enum logic [ST_W-1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALTED   = 2'd2,
      ILLEGAL  = 2'd3
   } state_t;

   // Opcode the IF/ID latch loads when asked to insert a NOP.
   localparam logic [OPC_W-1:0] NOP_OPCODE = 5'b00001;

   // Per-cycle pipeline control bundle.
   typedef struct packed {
      logic pc_en;
      logic if_id_en;
      logic if_id_nop;
      logic id_ex_en;
      logic id_ex_nop;
      logic ex_mem_en;
      logic mem_wb_en;
      logic mem_wb_nop;
      logic halted;
   } ctrl_t;

   //                                pc ifen ifnop exen exnop mem wben wbnop halt
   localparam ctrl_t CTRL_RESET = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
   localparam ctrl_t CTRL_HALT  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   localparam ctrl_t CTRL_DMEM  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
   localparam ctrl_t CTRL_FLUSH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   localparam ctrl_t CTRL_HZ    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   localparam ctrl_t CTRL_IMEM  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
   localparam ctrl_t CTRL_NORM  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard requests in, pipeline-register controls and perf counters out.
interface pipe_stall_ctrl_if #(
   parameter int unsigned CNT_W = pipe_stall_ctrl_pkg::CNT_W_DEF
);
   logic             hz_stall;
   logic             redirect_x;
   logic             imem_busy;
   logic             dmem_busy;
   logic             halt_wb;

   logic             pc_en;
   logic             if_id_en;
   logic             if_id_nop;
   logic             id_ex_en;
   logic             id_ex_nop;
   logic             ex_mem_en;
   logic             mem_wb_en;
   logic             mem_wb_nop;
   logic             halted;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] bubble_cnt;

   // Pipeline side: raises requests, consumes controls.
   modport master (
      output hz_stall, redirect_x, imem_busy, dmem_busy, halt_wb,
      input  pc_en, if_id_en, if_id_nop, id_ex_en, id_ex_nop,
             ex_mem_en, mem_wb_en, mem_wb_nop, halted, stall_cnt, bubble_cnt
   );

   // Controller side.
   modport slave (
      input  hz_stall, redirect_x, imem_busy, dmem_busy, halt_wb,
      output pc_en, if_id_en, if_id_nop, id_ex_en, id_ex_nop,
             ex_mem_en, mem_wb_en, mem_wb_nop, halted, stall_cnt, bubble_cnt
   );
endinterface

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   // Count up on inc, hold at all ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (inc && (cnt != {W{1'b1}})) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Decode-stage hazard consumer: per-stage enables, bubbles, PC enable,
// pending-flush tracking across data-memory waits, halt and perf counters.
module pipe_stall_ctrl
   import pipe_stall_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   pipe_stall_ctrl_if.slave   bus
);

   state_t state;
   logic   flush_pend;
   ctrl_t  ctrl;
   logic   flush;
   logic   stall_inc;
   logic   bubble_inc;

   // A redirect seen during a memory wait is replayed once the wait ends.
   assign flush = bus.redirect_x | flush_pend;

   // Priority decode of the current cycle's pipeline controls.
   always_comb begin
      ctrl = CTRL_NORM;
      if (rst) begin
         ctrl = CTRL_RESET;
      end else if (state == HALTED) begin
         ctrl = CTRL_HALT;
      end else if (bus.dmem_busy) begin
         ctrl = CTRL_DMEM;
      end else if (flush) begin
         ctrl = CTRL_FLUSH;
      end else if (bus.hz_stall) begin
         ctrl = CTRL_HZ;
      end else if (bus.imem_busy) begin
         ctrl = CTRL_IMEM;
      end
   end

   // State and pending-flush update; MEM_WAIT exits the same cycle busy drops.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= RUN;
         flush_pend <= 1'b0;
      end else begin
         case (state)
            HALTED: begin
               state <= HALTED;
            end
            default: begin
               if (bus.dmem_busy) begin
                  state <= MEM_WAIT;
                  if (bus.redirect_x) begin
                     flush_pend <= 1'b1;
                  end
               end else begin
                  flush_pend <= 1'b0;
                  state      <= bus.halt_wb ? HALTED : RUN;
               end
            end
         endcase
      end
   end

   assign bus.pc_en      = ctrl.pc_en;
   assign bus.if_id_en   = ctrl.if_id_en;
   assign bus.if_id_nop  = ctrl.if_id_nop;
   assign bus.id_ex_en   = ctrl.id_ex_en;
   assign bus.id_ex_nop  = ctrl.id_ex_nop;
   assign bus.ex_mem_en  = ctrl.ex_mem_en;
   assign bus.mem_wb_en  = ctrl.mem_wb_en;
   assign bus.mem_wb_nop = ctrl.mem_wb_nop;
   assign bus.halted     = ctrl.halted;

   // Stalls count only while the core is live; halted cycles are frozen.
   assign stall_inc  = ~rst & (state != HALTED) & ~ctrl.pc_en;
   assign bubble_inc = ~rst & ctrl.id_ex_nop;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (stall_inc),
      .cnt (bus.stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_bubble_cnt (
      .clk (clk),
      .rst (rst),
      .inc (bubble_inc),
      .cnt (bus.bubble_cnt)
   );

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Consumer end of the decode-stage hazard interface. Takes the load-use stall request, redirect/flush requests from execute, and busy signals from the instruction and data memories.
- Produces per-stage pipeline-register enables, bubble/squash controls and the PC enable for the 5-stage pipeline.
- Tracks pending flushes across memory waits, a halted state, and stall/bubble performance counters.

Parameters:
- CNT_W, 16, width of the performance counters (saturating).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- hz_stall  in  1  load-use stall request from decode hazard logic
- redirect_x  in  1  taken branch/jump resolved in execute; squash younger instructions
- imem_busy  in  1  instruction memory not ready this cycle
- dmem_busy  in  1  data memory not ready (multi-cycle access in memory stage)
- halt_wb  in  1  HALT instruction is in writeback
- pc_en  out  1  PC register load enable
- if_id_en  out  1  IF/ID latch enable
- if_id_nop  out  1  load NOP into IF/ID instead of fetched word
- id_ex_en  out  1  ID/EX latch enable
- id_ex_nop  out  1  load bubble (all control zero) into ID/EX
- ex_mem_en  out  1  EX/MEM latch enable
- mem_wb_en  out  1  MEM/WB latch enable
- mem_wb_nop  out  1  load bubble into MEM/WB
- halted  out  1  core halted
- stall_cnt  out  CNT_W  cycles with pc_en=0 while not halted
- bubble_cnt  out  CNT_W  cycles with id_ex_nop=1

Behaviour:
- States: RUN, MEM_WAIT, HALTED. The state register and flush_pend register are sequential. Enables are combinational from state and inputs.
- Reset (rst=1 at a clk edge): state=RUN, flush_pend=0, counters=0.
- While rst=1, outputs are forced:
  - all *_en=0
  - all *_nop=1
  - halted=0
- Priority per cycle, highest first: HALTED > dmem_busy > redirect (or flush_pend) > hz_stall > imem_busy > normal.
- HALTED:
  - all enables 0, all nop 0, halted=1.
  - Left only by rst. Counters freeze.
- dmem_busy=1 (any non-halted state):
  - next state MEM_WAIT.
  - pc_en, if_id_en, id_ex_en, ex_mem_en = 0.
  - mem_wb_en=1 with mem_wb_nop=1, so writeback retires a bubble and the in-flight op is not duplicated.
  - If redirect_x=1 in the same cycle, set flush_pend=1.
- MEM_WAIT with dmem_busy=0:
  - return to RUN and evaluate the remaining priorities in the same cycle. Zero extra latency after busy drops.
- Redirect (redirect_x | flush_pend):
  - pc_en=1 (PC loads target).
  - if_id_en=1 with if_id_nop=1.
  - id_ex_en=1 with id_ex_nop=1.
  - ex_mem_en=1, mem_wb_en=1.
  - Clear flush_pend.
  - A concurrent hz_stall is ignored, because the stalled instruction is squashed.
- hz_stall:
  - pc_en=0, if_id_en=0.
  - id_ex_en=1 with id_ex_nop=1.
  - ex_mem_en=1, mem_wb_en=1.
  - Exactly one bubble per asserted cycle.
- imem_busy:
  - pc_en=0.
  - if_id_en=1 with if_id_nop=1.
  - Downstream stages advance normally.
- Normal: all enables 1, all nop 0.
- halt_wb=1 with dmem_busy=0: next state HALTED. The current cycle's outputs follow the rules above.
- Counters:
  - stall_cnt increments when pc_en=0 in RUN/MEM_WAIT and rst=0.
  - bubble_cnt increments when id_ex_nop=1 and rst=0.
  - Both saturate at all ones; no wrap.

Decomposition:
- Shared package holds:
  - state encoding localparams: RUN=2'd0, MEM_WAIT=2'd1, HALTED=2'd2; 2'd3 is illegal and returns to RUN.
  - NOP opcode constant 5'b00001, used by the IF/ID latch.
- One sub-module, sat_counter (parameter W; inputs clk, rst, inc; output cnt), instantiated twice.
- The pipeline latches stay in their existing modules.

Test Plan:
- Reset: rst=1 for 2 cycles, then 0, no requests. During reset all en=0 and nop=1; first cycle after, all en=1, nop=0, counters 0.
- Load-use: hz_stall=1 for one cycle. pc_en=0, if_id_en=0, id_ex_nop=1 in that cycle; next cycle normal; stall_cnt=1, bubble_cnt=1.
- Memory wait with redirect: dmem_busy=1 for 3 cycles with redirect_x=1 in cycle 1.
  - Cycles 1-3: ex_mem_en=0, mem_wb_nop=1.
  - Cycle 4: if_id_nop=1, id_ex_nop=1, pc_en=1.
  - stall_cnt=3.
- Simultaneous hz_stall+redirect_x: squash wins. pc_en=1, if_id_nop=1, id_ex_nop=1.
- Fetch miss: imem_busy=1 for 2 cycles. pc_en=0, if_id_nop=1, id_ex_en=1, id_ex_nop=0 both cycles.
- Halt: halt_wb=1 once. Next cycle halted=1, all en=0, counters frozen for 10 cycles; rst returns to RUN. Also run with counters preloaded via stimulus to 16'hFFFF; they must stay 16'hFFFF on further stalls.
